// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle ARM main controller: state codes,
// datapath mux select codes and instruction Op classes.
package mainfsm_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Moore main controller sequencing fetch, decode, address generation,
// memory access, execute and write-back for the multicycle ARM datapath.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: a default before the case keeps every path assigned, so no latch
  // is inferred; unused codes 11-15 fall to the default like UNKNOWN.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      // PC+8 is formed here for use as R15 by the following instruction step.
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      S_ALUWB:    RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Moore main controller that sequences the multicycle ARM datapath: fetch, decode, address generation, memory access, execute and write-back.
- Emits unconditioned write requests (NextPC, RegW, MemW, Branch). The conditional-logic unit gates these with the registered condition result.
- Emits mux selects and the ALUOp request consumed by the ALU decoder.
- Sits in the control unit, beside the instruction decoder and the conditional-logic unit.

Parameters:
- STATE_W, 4, width of the state register and of state_o. Fixed; values other than 4 are unsupported.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; only Funct[5] (I) and Funct[0] (L) are used
- IRWrite  out  1  load the instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register
- ALUSrcA  out  1  ALU A select: 0 = RD1 register, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = RD2 register, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data register, 10 = ALUResult
- NextPC  out  1  unconditional PC write (fetch)
- RegW  out  1  register-file write request, before condition gating
- MemW  out  1  memory write request, before condition gating
- Branch  out  1  conditional PC write request
- ALUOp  out  1  1 = ALU decoder decodes Funct; 0 = force ADD
- state_o  out  STATE_W  current state, for debug and verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Codes 11-15 behave exactly as UNKNOWN.
- Reset: state forced to FETCH asynchronously.
  - While reset is high, outputs equal the FETCH decode, including NextPC=1 and IRWrite=1. This is harmless because the PC and IR are also held in reset.
  - Deasserting reset mid-instruction discards the in-flight instruction; the next edge goes to DECODE.
- Outputs are purely a function of the state (Moore). Any field not listed for a state drives 0, never X.
- Transitions, one per rising clk:
  - FETCH -> DECODE
  - DECODE:
    - Op=00, Funct[5]=0 -> EXECUTER
    - Op=00, Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> UNKNOWN
  - MEMADR: Funct[0]=1 -> MEMREAD, else -> MEMWRITE
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER, EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
  - UNKNOWN -> FETCH (the illegal instruction is skipped; no state writes)
- Op and Funct are sampled only in DECODE and MEMADR. They are stable there because IR is written only in FETCH.
- Output decode per state:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8)
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
  - UNKNOWN: all outputs 0
- Timing contract with the conditional-logic unit:
  - The condition result is registered one cycle after MEMADR, EXECUTER or EXECUTEI.
  - RegW/MemW in MEMWB, MEMWRITE and ALUWB are therefore gated by that registered result.
  - Branch is asserted in the cycle after DECODE.
- Instruction latency: data-processing 4 cycles, LDR 5, STR 4, B 3, illegal 3.

Decomposition:
- Shared package: state localparams, ALUSrcB codes (SRCB_RD2, SRCB_IMM, SRCB_FOUR), ResultSrc codes (RES_ALUOUT, RES_DATA, RES_ALURESULT), Op codes (OP_DP, OP_MEM, OP_BR).
- No sub-module: one state register, one next-state case statement and one output case statement.

Test Plan:
- Reset held for 3 cycles, then released -> state_o=0, IRWrite=1, NextPC=1, ALUSrcB=10; after release state_o goes 1 then 6 for Op=00, Funct=6'b000100.
- ADD register (Op=00, Funct[5]=0) -> state_o sequence 0,1,6,8,0; RegW=1 only in state 8; ALUOp=1 only in state 6.
- LDR (Op=01, Funct=6'b011001) -> sequence 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4.
- STR (Op=01, Funct[0]=0) -> sequence 0,1,2,5,0; MemW=1 and AdrSrc=1 in state 5; RegW=0 throughout.
- Branch (Op=10) then illegal (Op=11) -> 0,1,9,0 with Branch=1 only in state 9; then 0,1,10,0 with all outputs 0 in state 10.
- Async reset asserted mid-MEMREAD (state 3), between clock edges -> state_o=0 immediately without a clock edge; no RegW pulse follows.
